// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: VGA timing defaults and types shared by the horizontal and vertical stages
package vga_timing_pkg;
  localparam int H_TOTAL   = 1575;
  localparam int H_SYNC    = 189;
  localparam int H_BACK    = 74;
  localparam int H_ACTIVE  = 1280;
  localparam int H_FRONT   = 32;
  localparam int PIXEL_DIV = 2;
  localparam int V_ACTIVE  = 480;
  localparam int COLOR_W   = 8;
  typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} h_state_t;
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/vga_pixel_divider.sv
// vga_pixel_divider: sub-pixel phase counter plus pixel index counter
// VGA_CLOCK/VGA_RESET_N: clock and asynchronous active-low reset
// en: advance while high, clear both counters while low
// sub: phase within the current pixel (0 on its first clock); cnt: pixel index
module vga_pixel_divider
  import vga_timing_pkg::*;
#(
  parameter int DIV = PIXEL_DIV,
  parameter int W = 10,
  localparam int SW = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic          VGA_CLOCK,
  input  logic          VGA_RESET_N,
  input  logic          en,
  output logic [SW-1:0] sub,
  output logic [W-1:0]  cnt
);
  logic last;
  assign last = sub == SW'(DIV - 1);
  always_ff @(posedge VGA_CLOCK or negedge VGA_RESET_N)
    if (!VGA_RESET_N) begin
      sub <= '0;
      cnt <= '0;
    end else if (!en) begin
      sub <= '0;
      cnt <= '0;
    end else begin
      sub <= last ? '0 : sub + 1'b1;
      cnt <= last ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/vga_hsync_pixel_timing.sv
// vga_hsync_pixel_timing: horizontal sync, renderer pixel coordinates and registered VGA DAC pins
// VGA_CLOCK/VGA_RESET_N: pixel clock and asynchronous active-low reset
// ENABLE: vertical active window from the vsync stage; FRAME_START pulses once on its rising edge
// PIXEL_X/PIXEL_Y/PIXEL_VALID/PIXEL_STROBE: renderer address and pixel pulse, one clock after h_cnt
// RGB_IN: renderer colour for the current address, sampled in the same cycle
// VGA_HS/VGA_BLANK_N/VGA_R/VGA_G/VGA_B: DAC pins, all two clocks after h_cnt
module vga_hsync_pixel_timing
  import vga_timing_pkg::*;
#(
  parameter int H_TOT   = H_TOTAL,
  parameter int H_SYN   = H_SYNC,
  parameter int H_BP    = H_BACK,
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FP    = H_FRONT,
  parameter int PIX_DIV = PIXEL_DIV,
  parameter int V_ACT   = V_ACTIVE
) (
  input  logic                 VGA_CLOCK,
  input  logic                 VGA_RESET_N,
  input  logic                 ENABLE,
  input  logic [3*COLOR_W-1:0] RGB_IN,
  output logic [9:0]           PIXEL_X,
  output logic [9:0]           PIXEL_Y,
  output logic                 PIXEL_VALID,
  output logic                 PIXEL_STROBE,
  output logic                 FRAME_START,
  output logic                 VGA_HS,
  output logic                 VGA_BLANK_N,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B
);
  localparam int HW = $clog2(H_TOT);
  localparam int SW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  if (H_SYN + H_BP + H_ACT + H_FP != H_TOT) begin : g_bad_h_sum
    $error("horizontal sync, porches and active period do not add up to H_TOT");
  end
  if (H_ACT % PIX_DIV != 0) begin : g_bad_pix_div
    $error("H_ACT is not a whole number of pixels");
  end
  h_state_t      state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic          wrap;
  logic          enable_q, enable_qq;
  logic          armed;
  logic [9:0]    line_cnt;
  logic [SW-1:0] sub;
  logic [9:0]    div_x;
  logic          vis;
  logic          hs_s1;
  rgb_t          rgb;
  assign wrap        = h_cnt == HW'(H_TOT - 1);
  assign rgb         = RGB_IN;
  assign FRAME_START = enable_q & ~enable_qq;
  // armed: ENABLE_q was already high before this line's active region began,
  // so a window opening mid-line never shows or counts a partial line
  assign vis = state == ACTIVE && enable_q && armed && line_cnt < 10'(V_ACT);
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (h_cnt == HW'(H_SYN - 1)) state_nxt = BACK;
      BACK:    if (h_cnt == HW'(H_SYN + H_BP - 1)) state_nxt = ACTIVE;
      ACTIVE:  if (h_cnt == HW'(H_SYN + H_BP + H_ACT - 1)) state_nxt = FRONT;
      default: if (wrap) state_nxt = SYNC;
    endcase
  end
  always_ff @(posedge VGA_CLOCK or negedge VGA_RESET_N)
    if (!VGA_RESET_N) begin
      h_cnt <= '0;
      state <= SYNC;
    end else begin
      h_cnt <= wrap ? '0 : h_cnt + 1'b1;
      state <= state_nxt;
    end
  always_ff @(posedge VGA_CLOCK or negedge VGA_RESET_N)
    if (!VGA_RESET_N) begin
      enable_q  <= 1'b0;
      enable_qq <= 1'b0;
      armed     <= 1'b0;
      line_cnt  <= '0;
    end else begin
      enable_q  <= ENABLE;
      enable_qq <= enable_q;
      armed     <= enable_q && (armed || state == SYNC || state == BACK);
      line_cnt  <= !enable_q ? '0 : (wrap && armed && line_cnt < 10'(V_ACT)) ? line_cnt + 1'b1 : line_cnt;
    end
  vga_pixel_divider #(.DIV(PIX_DIV), .W(10)) u_div (
    .VGA_CLOCK  (VGA_CLOCK),
    .VGA_RESET_N(VGA_RESET_N),
    .en         (state == ACTIVE),
    .sub        (sub),
    .cnt        (div_x)
  );
  always_ff @(posedge VGA_CLOCK or negedge VGA_RESET_N)
    if (!VGA_RESET_N) begin
      PIXEL_VALID  <= 1'b0;
      PIXEL_STROBE <= 1'b0;
      PIXEL_X      <= '0;
      PIXEL_Y      <= '0;
      hs_s1        <= 1'b1;
      VGA_HS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
      VGA_R        <= '0;
      VGA_G        <= '0;
      VGA_B        <= '0;
    end else begin
      PIXEL_VALID  <= vis;
      PIXEL_STROBE <= vis && sub == '0;
      PIXEL_X      <= vis ? div_x : '0;
      PIXEL_Y      <= vis ? line_cnt : '0;
      hs_s1        <= state != SYNC;
      VGA_HS       <= hs_s1;
      VGA_BLANK_N  <= PIXEL_VALID;
      VGA_R        <= PIXEL_VALID ? rgb.r : '0;
      VGA_G        <= PIXEL_VALID ? rgb.g : '0;
      VGA_B        <= PIXEL_VALID ? rgb.b : '0;
    end
endmodule
